// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter funnelling execution-unit results onto one registered result/carry broadcast bus.
// Optional macro RESULT_BUS_STATS_EN adds saturating per-unit grant counters and a conflict counter.
module result_bus_arbiter #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [UNITS-1:0]             unit_valid,
  output logic [UNITS-1:0]             unit_ready,
  input  logic [UNITS*RS_ID_WIDTH-1:0] unit_rs_id,
  input  logic [UNITS*5-1:0]           unit_reg_addr,
  input  logic [UNITS*32-1:0]          unit_result,
  input  logic [UNITS-1:0]             unit_ca_write,
  input  logic [UNITS-1:0]             unit_ca,
  input  logic                         bus_stall,
  output logic                         update_op_valid,
  output logic [RS_ID_WIDTH-1:0]       update_op_rs_id_out,
  output logic [31:0]                  update_op_value_out,
  output logic                         update_carry_valid,
  output logic [RS_ID_WIDTH-1:0]       update_carry_rs_id_out,
  output logic [31:0]                  update_carry_value_out,
  output logic [4:0]                   gpr_write_addr
`ifdef RESULT_BUS_STATS_EN
  ,
  output logic [UNITS*16-1:0]          grant_count,
  output logic [15:0]                  conflict_count
`endif
);

  localparam int                PTR_W    = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam logic [PTR_W:0]    UNITS_W  = (PTR_W+1)'(UNITS);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(UNITS - 1);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   grant_vld;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W:0]         cand;

  logic [RS_ID_WIDTH-1:0] sel_rs_id;
  logic [4:0]             sel_addr;
  logic [31:0]            sel_result;
  logic                   sel_ca_write;
  logic                   sel_ca;

  logic                   op_valid_q;
  logic                   carry_valid_q;
  logic [RS_ID_WIDTH-1:0] rs_id_q;
  logic [31:0]            value_q;
  logic [4:0]             addr_q;
  logic                   ca_q;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // Rotating scan: first valid unit at or after ptr, wrapping modulo UNITS.
    for (int k = 0; k < UNITS; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= UNITS_W) cand = cand - UNITS_W;
      if (!grant_vld && unit_valid[cand[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    if (bus_stall || !rst) grant_vld = 1'b0;
  end

  assign unit_ready = grant_vld ? (UNITS'(1) << grant_idx) : '0;

  always_comb begin
    sel_rs_id    = '0;
    sel_addr     = '0;
    sel_result   = '0;
    sel_ca_write = 1'b0;
    sel_ca       = 1'b0;
    for (int i = 0; i < UNITS; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_rs_id    = unit_rs_id[i*RS_ID_WIDTH +: RS_ID_WIDTH];
        sel_addr     = unit_reg_addr[i*5 +: 5];
        sel_result   = unit_result[i*32 +: 32];
        sel_ca_write = unit_ca_write[i];
        sel_ca       = unit_ca[i];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q         <= '0;
      op_valid_q    <= 1'b0;
      carry_valid_q <= 1'b0;
      rs_id_q       <= '0;
      value_q       <= '0;
      addr_q        <= '0;
      ca_q          <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      op_valid_q    <= grant_vld;
      carry_valid_q <= grant_vld & sel_ca_write;
      // Data fields hold between transfers; only the valids pulse.
      if (grant_vld) begin
        rs_id_q <= sel_rs_id;
        value_q <= sel_result;
        addr_q  <= sel_addr;
      end
      if (grant_vld && sel_ca_write) ca_q <= sel_ca;
    end
  end

  assign update_op_valid        = op_valid_q;
  assign update_op_rs_id_out    = rs_id_q;
  assign update_op_value_out    = value_q;
  assign gpr_write_addr         = addr_q;
  assign update_carry_valid     = carry_valid_q;
  assign update_carry_rs_id_out = rs_id_q;
  assign update_carry_value_out = {ca_q, 31'b0};

`ifdef RESULT_BUS_STATS_EN
  logic [15:0] grant_cnt_q [UNITS];
  logic [15:0] conflict_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < UNITS; i++) grant_cnt_q[i] <= '0;
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < UNITS; i++) begin
        if (grant_vld && grant_idx == PTR_W'(i) && grant_cnt_q[i] != 16'hFFFF)
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
      if (!bus_stall && $countones(unit_valid) >= 2 && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
    end
  end

  for (genvar g = 0; g < UNITS; g++) begin : g_cnt
    assign grant_count[g*16 +: 16] = grant_cnt_q[g];
  end
  assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: stimulus pushes expected broadcasts, a negedge monitor pops and compares.
module tb_result_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  unit_valid;
  logic [3:0]  unit_ready;
  logic [19:0] unit_rs_id;
  logic [19:0] unit_reg_addr;
  logic [127:0] unit_result;
  logic [3:0]  unit_ca_write;
  logic [3:0]  unit_ca;
  logic        bus_stall;
  logic        update_op_valid;
  logic [4:0]  update_op_rs_id_out;
  logic [31:0] update_op_value_out;
  logic        update_carry_valid;
  logic [4:0]  update_carry_rs_id_out;
  logic [31:0] update_carry_value_out;
  logic [4:0]  gpr_write_addr;
`ifdef RESULT_BUS_STATS_EN
  logic [63:0] grant_count;
  logic [15:0] conflict_count;
`endif

  result_bus_arbiter #(.UNITS(4), .RS_ID_WIDTH(5)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .unit_valid             (unit_valid),
    .unit_ready             (unit_ready),
    .unit_rs_id             (unit_rs_id),
    .unit_reg_addr          (unit_reg_addr),
    .unit_result            (unit_result),
    .unit_ca_write          (unit_ca_write),
    .unit_ca                (unit_ca),
    .bus_stall              (bus_stall),
    .update_op_valid        (update_op_valid),
    .update_op_rs_id_out    (update_op_rs_id_out),
    .update_op_value_out    (update_op_value_out),
    .update_carry_valid     (update_carry_valid),
    .update_carry_rs_id_out (update_carry_rs_id_out),
    .update_carry_value_out (update_carry_value_out),
    .gpr_write_addr         (gpr_write_addr)
`ifdef RESULT_BUS_STATS_EN
    ,
    .grant_count            (grant_count),
    .conflict_count         (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs;
    logic [31:0] val;
    logic [4:0]  ad;
    logic        cv;
    logic [31:0] cval;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          mon_en = 0;

  logic [4:0]  rs  [4];
  logic [4:0]  ad  [4];
  logic [31:0] res [4];
  logic        cw  [4];
  logic        ca  [4];

  always_comb begin
    unit_rs_id    = '0;
    unit_reg_addr = '0;
    unit_result   = '0;
    unit_ca_write = '0;
    unit_ca       = '0;
    for (int i = 0; i < 4; i++) begin
      unit_rs_id[i*5 +: 5]     = rs[i];
      unit_reg_addr[i*5 +: 5]  = ad[i];
      unit_result[i*32 +: 32]  = res[i];
      unit_ca_write[i]         = cw[i];
      unit_ca[i]               = ca[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1 with inputs set; checks the grant, records the expected broadcast, advances one cycle.
  task automatic step(input logic [3:0] exp_ready);
    exp_t e;
    #1;
    check("unit_ready", {28'b0, unit_ready}, {28'b0, exp_ready});
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        e.rs   = rs[i];
        e.val  = res[i];
        e.ad   = ad[i];
        e.cv   = cw[i];
        e.cval = {ca[i], 31'b0};
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        rs[i]  = rs[i] + 5'd1;
        res[i] = res[i] + 32'h0101_1111;
        ca[i]  = ~ca[i];
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (update_op_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_bcast", {31'b0, update_op_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bcast_cycle", cyc, e.cyc);
          check("op_rs_id", {27'b0, update_op_rs_id_out}, {27'b0, e.rs});
          check("op_value", update_op_value_out, e.val);
          check("gpr_addr", {27'b0, gpr_write_addr}, {27'b0, e.ad});
          check("carry_valid", {31'b0, update_carry_valid}, {31'b0, e.cv});
          check("carry_rs_id", {27'b0, update_carry_rs_id_out}, {27'b0, e.rs});
          if (e.cv) check("carry_value", update_carry_value_out, e.cval);
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check("missing_bcast", {31'b0, update_op_valid}, 32'd1);
          void'(exp_q.pop_front());
        end
        check("carry_idle", {31'b0, update_carry_valid}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    bus_stall  = 1'b0;
    unit_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      rs[i]  = 5'(i + 1);
      ad[i]  = 5'(i + 10);
      res[i] = {8'(i), 24'hA5A5A5};
      cw[i]  = (i % 2) == 1;
      ca[i]  = 1'b1;
    end

    // Reset with every unit requesting: nothing granted, all outputs cleared.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready", {28'b0, unit_ready}, 32'd0);
    check("rst_op_valid", {31'b0, update_op_valid}, 32'd0);
    check("rst_carry_valid", {31'b0, update_carry_valid}, 32'd0);
    check("rst_rs_id", {27'b0, update_op_rs_id_out}, 32'd0);
    check("rst_value", update_op_value_out, 32'd0);
    check("rst_addr", {27'b0, gpr_write_addr}, 32'd0);
    check("rst_carry_value", update_carry_value_out, 32'd0);
    mon_en = 1;
    rst    = 1'b1;

    // All four valid: strict rotation 0,1,2,3,0,1,2,3 with back-to-back broadcasts.
    for (int k = 0; k < 8; k++) step(4'b0001 << (k % 4));
    unit_valid = 4'b0000;

    // Single unit 2 with the hand-written payload.
    rs[2] = 5'h07; ad[2] = 5'd3; res[2] = 32'hDEADBEEF; cw[2] = 1'b1; ca[2] = 1'b1;
    unit_valid = 4'b0100;
    step(4'b0100);
    unit_valid = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    // ptr=3: unit 1 alone moves ptr to 2; then units 1 and 3 -> 3 first, then 1.
    unit_valid = 4'b0010;
    step(4'b0010);
    unit_valid = 4'b1010;
    step(4'b1000);
    unit_valid = 4'b0010;
    step(4'b0010);
    unit_valid = 4'b1111;
    step(4'b0100);

    // ptr=3: grant unit 3, then stall three cycles with unit 0 waiting.
    unit_valid = 4'b1000;
    step(4'b1000);
    unit_valid = 4'b0001;
    bus_stall  = 1'b1;
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);
    bus_stall = 1'b0;
    step(4'b0001);

    // ptr=1 with units 0 and 3 waiting; reset forces the scan to restart at 0.
    unit_valid = 4'b1001;
    rst = 1'b0;
    step(4'b0000);
    rst = 1'b1;
    step(4'b0001);
    unit_valid = 4'b1000;
    step(4'b1000);
    unit_valid = 4'b0000;
    step(4'b0000);

`ifdef RESULT_BUS_STATS_EN
    // Counters cleared by the mid-run reset: unit0=1, unit3=1, one conflict cycle since.
    unit_valid = 4'b0010;
    for (int k = 0; k < 70000; k++) step(4'b0010);
    unit_valid = 4'b0000;
    step(4'b0000);
    check("gc_unit1_sat", {16'b0, grant_count[16 +: 16]}, 32'h0000FFFF);
    check("gc_unit0", {16'b0, grant_count[0 +: 16]}, 32'd1);
    check("gc_unit2", {16'b0, grant_count[32 +: 16]}, 32'd0);
    check("gc_unit3", {16'b0, grant_count[48 +: 16]}, 32'd1);
    check("conflict_count", {16'b0, conflict_count}, 32'd1);
`endif

    step(4'b0000);
    step(4'b0000);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
